// File: rtl/serpent_xts_pkg.sv
// Shared constants and state encodings for the Serpent XTS tweak/whitening stage.
package serpent_xts_pkg;

  localparam int XTS_BLOCK_W = 128;
  localparam logic [7:0] XTS_GF_POLY = 8'h87;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] READY  = 2'b01;
  localparam logic [1:0] CIPHER = 2'b10;

endpackage

// File: rtl/serpent_xts_tweak_if.sv
// Block, tweak and core-side handshake bundle of serpent_xts_tweak.
interface serpent_xts_tweak_if;
  import serpent_xts_pkg::*;

  logic                   i_tweak_valid;
  logic [XTS_BLOCK_W-1:0] i_tweak;
  logic                   o_tweak_ready;
  logic                   i_blk_valid;
  logic [XTS_BLOCK_W-1:0] i_blk_data;
  logic                   o_blk_ready;
  logic [XTS_BLOCK_W-1:0] o_pre_data;
  logic                   o_pre_valid;
  logic                   i_post_valid;
  logic [XTS_BLOCK_W-1:0] i_post_data;
  logic [XTS_BLOCK_W-1:0] o_data;
  logic                   o_data_valid;
  logic                   o_busy;

  modport master (
    output i_tweak_valid, i_tweak, i_blk_valid, i_blk_data, i_post_valid, i_post_data,
    input  o_tweak_ready, o_blk_ready, o_pre_data, o_pre_valid, o_data, o_data_valid, o_busy
  );

  modport slave (
    input  i_tweak_valid, i_tweak, i_blk_valid, i_blk_data, i_post_valid, i_post_data,
    output o_tweak_ready, o_blk_ready, o_pre_data, o_pre_valid, o_data, o_data_valid, o_busy
  );

endinterface

// File: rtl/xts_gf_mul_alpha.sv
// Multiply a 128-bit little-endian tweak by alpha in GF(2^128) (IEEE 1619).
module xts_gf_mul_alpha
  import serpent_xts_pkg::*;
(
  input  logic [XTS_BLOCK_W-1:0] tweak_in,
  output logic [XTS_BLOCK_W-1:0] tweak_out
);

  logic [7:0] fold_s;

  assign fold_s    = tweak_in[XTS_BLOCK_W-1] ? XTS_GF_POLY : 8'h00;
  assign tweak_out = {tweak_in[XTS_BLOCK_W-2:0], 1'b0} ^ {{(XTS_BLOCK_W-8){1'b0}}, fold_s};

endmodule

// File: rtl/serpent_xts_tweak.sv
// XTS tweak capture, pre/post whitening and alpha advance around a Serpent core.
// Optional abort input enabled by defining SERPENT_XTS_ABORT_EN.
module serpent_xts_tweak
  import serpent_xts_pkg::*;
#(
  parameter int MAX_BLOCKS = 32
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef SERPENT_XTS_ABORT_EN
  input  logic i_abort,
`endif
  serpent_xts_tweak_if.slave bus
);

  localparam int CNT_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(MAX_BLOCKS - 1);

  logic [1:0]             state_r, state_s;
  logic [XTS_BLOCK_W-1:0] tweak_r, tweak_s, alpha_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [XTS_BLOCK_W-1:0] pre_data_r, pre_data_s;
  logic                   pre_valid_r, pre_valid_s;
  logic [XTS_BLOCK_W-1:0] data_r, data_s;
  logic                   data_valid_r, data_valid_s;
  logic                   busy_r, blk_ready_r, tweak_ready_r;

  xts_gf_mul_alpha u_alpha (
    .tweak_in  (tweak_r),
    .tweak_out (alpha_s)
  );

  // Next-state and datapath decisions for the tweak/block sequencer.
  always_comb begin
    state_s      = state_r;
    tweak_s      = tweak_r;
    cnt_s        = cnt_r;
    pre_data_s   = pre_data_r;
    pre_valid_s  = pre_valid_r;
    data_s       = data_r;
    data_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_tweak_valid) begin
          tweak_s = bus.i_tweak;
          cnt_s   = '0;
          state_s = READY;
        end else begin
          state_s = IDLE;
        end
      end
      READY: begin
        if (bus.i_blk_valid) begin
          pre_data_s  = bus.i_blk_data ^ tweak_r;
          pre_valid_s = 1'b1;
          state_s     = CIPHER;
        end else begin
          state_s = READY;
        end
      end
      CIPHER: begin
        if (bus.i_post_valid) begin
          data_s       = bus.i_post_data ^ tweak_r;
          data_valid_s = 1'b1;
          pre_valid_s  = 1'b0;
          tweak_s      = alpha_s;
          cnt_s        = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BLK) begin
            state_s = IDLE;
          end else begin
            state_s = READY;
          end
        end else begin
          state_s = CIPHER;
        end
      end
      default: begin
        state_s     = IDLE;
        pre_valid_s = 1'b0;
      end
    endcase
  end

  // State, tweak and registered outputs; status flags follow the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= IDLE;
      tweak_r       <= '0;
      cnt_r         <= '0;
      pre_data_r    <= '0;
      pre_valid_r   <= 1'b0;
      data_r        <= '0;
      data_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      blk_ready_r   <= 1'b0;
      tweak_ready_r <= 1'b1;
`ifdef SERPENT_XTS_ABORT_EN
    end else if (i_abort) begin
      state_r       <= IDLE;
      tweak_r       <= '0;
      cnt_r         <= '0;
      pre_valid_r   <= 1'b0;
      data_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      blk_ready_r   <= 1'b0;
      tweak_ready_r <= 1'b1;
`endif
    end else begin
      state_r       <= state_s;
      tweak_r       <= tweak_s;
      cnt_r         <= cnt_s;
      pre_data_r    <= pre_data_s;
      pre_valid_r   <= pre_valid_s;
      data_r        <= data_s;
      data_valid_r  <= data_valid_s;
      busy_r        <= (state_s != IDLE);
      blk_ready_r   <= (state_s == READY);
      tweak_ready_r <= (state_s == IDLE);
    end
  end

  assign bus.o_pre_data    = pre_data_r;
  assign bus.o_pre_valid   = pre_valid_r;
  assign bus.o_data        = data_r;
  assign bus.o_data_valid  = data_valid_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_blk_ready   = blk_ready_r;
  assign bus.o_tweak_ready = tweak_ready_r;

endmodule

// File: tb/tb_serpent_xts_tweak.sv
// Randomized self-checking bench for serpent_xts_tweak with a behavioural XTS model and core stand-in.
module tb_serpent_xts_tweak;

  localparam int MAX_BLK = 32;

  logic clk;
  logic rst;
`ifdef SERPENT_XTS_ABORT_EN
  logic abort;
`endif
  int total;
  int bad;
  logic [127:0] core_key;

  serpent_xts_tweak_if bus ();

  serpent_xts_tweak #(.MAX_BLOCKS(MAX_BLK)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
`ifdef SERPENT_XTS_ABORT_EN
    .i_abort (abort),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Tweak times x in GF(2^128): double as a 129-bit integer, fold the overflow back in.
  function automatic logic [127:0] gf_double(input logic [127:0] t);
    logic [128:0] w;
    logic [128:0] top;
    top = 129'd1 << 128;
    w = {1'b0, t} * 129'd2;
    if (w >= top) begin
      w = (w - top) ^ 129'h87;
    end
    return w[127:0];
  endfunction

  // Stand-in for the Serpent core: any fixed bijection will do for checking the whitening.
  function automatic logic [127:0] core_model(input logic [127:0] x);
    return x ^ core_key;
  endfunction

  task automatic wait_tweak_ready();
    for (int i = 0; i < 20 && bus.o_tweak_ready !== 1'b1; i++) @(negedge clk);
    check_eq("tweak_ready_wait", {127'd0, bus.o_tweak_ready}, 128'd1);
  endtask

  task automatic run_sector(input logic [127:0] tw, input int nblk, input bit rand_data, input bit inject);
    logic [127:0] t;
    logic [127:0] p;
    logic [127:0] pre;
    logic [127:0] cc;
    int lat;
    bit stray;
    wait_tweak_ready();
    bus.i_tweak = tw;
    bus.i_tweak_valid = 1'b1;
    @(negedge clk);
    bus.i_tweak_valid = 1'b0;
    bus.i_tweak = '0;
    t = tw;
    check_eq("busy_after_tweak", {127'd0, bus.o_busy}, 128'd1);
    check_eq("tweak_ready_low", {127'd0, bus.o_tweak_ready}, 128'd0);
    for (int b = 0; b < nblk; b++) begin
      check_eq("blk_ready", {127'd0, bus.o_blk_ready}, 128'd1);
      if ($urandom_range(0, 3) == 0) begin
        bus.i_post_valid = 1'b1;
        bus.i_post_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.i_post_valid = 1'b0;
        check_eq("stray_post_ignored", {127'd0, bus.o_data_valid}, 128'd0);
        check_eq("stray_post_ready", {127'd0, bus.o_blk_ready}, 128'd1);
      end
      p = rand_data ? {$urandom, $urandom, $urandom, $urandom} : 128'd0;
      pre = p ^ t;
      bus.i_blk_valid = 1'b1;
      bus.i_blk_data = p;
      @(negedge clk);
      bus.i_blk_valid = 1'b0;
      check_eq("pre_valid", {127'd0, bus.o_pre_valid}, 128'd1);
      check_eq("pre_data", bus.o_pre_data, pre);
      check_eq("blk_ready_low", {127'd0, bus.o_blk_ready}, 128'd0);
      lat = $urandom_range(1, 6);
      stray = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < lat; k++) begin
        if (inject && k == 0) begin
          bus.i_tweak = 128'hFF;
          bus.i_tweak_valid = 1'b1;
        end
        bus.i_blk_valid = stray;
        bus.i_blk_data = ~p;
        @(negedge clk);
        bus.i_tweak_valid = 1'b0;
        check_eq("pre_data_hold", bus.o_pre_data, pre);
      end
      bus.i_blk_valid = 1'b0;
      cc = core_model(pre);
      bus.i_post_valid = 1'b1;
      bus.i_post_data = cc;
      @(negedge clk);
      bus.i_post_valid = 1'b0;
      check_eq("data_valid", {127'd0, bus.o_data_valid}, 128'd1);
      check_eq("data", bus.o_data, cc ^ t);
      check_eq("pre_valid_drop", {127'd0, bus.o_pre_valid}, 128'd0);
      if (b == MAX_BLK - 1) begin
        check_eq("busy_end", {127'd0, bus.o_busy}, 128'd0);
        check_eq("tweak_ready_end", {127'd0, bus.o_tweak_ready}, 128'd1);
        check_eq("blk_ready_end", {127'd0, bus.o_blk_ready}, 128'd0);
      end else begin
        check_eq("blk_ready_next", {127'd0, bus.o_blk_ready}, 128'd1);
      end
      @(negedge clk);
      check_eq("data_valid_pulse", {127'd0, bus.o_data_valid}, 128'd0);
      t = gf_double(t);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pre_data"}, bus.o_pre_data, 128'd0);
    check_eq({tag, "_pre_valid"}, {127'd0, bus.o_pre_valid}, 128'd0);
    check_eq({tag, "_data"}, bus.o_data, 128'd0);
    check_eq({tag, "_data_valid"}, {127'd0, bus.o_data_valid}, 128'd0);
    check_eq({tag, "_busy"}, {127'd0, bus.o_busy}, 128'd0);
    check_eq({tag, "_blk_ready"}, {127'd0, bus.o_blk_ready}, 128'd0);
    check_eq({tag, "_tweak_ready"}, {127'd0, bus.o_tweak_ready}, 128'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    core_key = '0;
    rst = 1'b1;
`ifdef SERPENT_XTS_ABORT_EN
    abort = 1'b0;
`endif
    bus.i_tweak_valid = 1'b0;
    bus.i_tweak = '0;
    bus.i_blk_valid = 1'b0;
    bus.i_blk_data = '0;
    bus.i_post_valid = 1'b0;
    bus.i_post_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Identity core, unit tweak, zero blocks: pre data walks 1,2,4..., output is zero.
    run_sector(128'h1, MAX_BLK, 1'b0, 1'b0);
    // Top-bit tweak: the second block sees the reduction polynomial.
    run_sector(128'h8000_0000_0000_0000_0000_0000_0000_0000, MAX_BLK, 1'b0, 1'b0);

    core_key = {$urandom, $urandom, $urandom, $urandom};
    run_sector({$urandom, $urandom, $urandom, $urandom}, MAX_BLK, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++) begin
      core_key = {$urandom, $urandom, $urandom, $urandom};
      run_sector({$urandom, $urandom, $urandom, $urandom}, MAX_BLK, 1'b1, s == 1);
    end

    // Tweak or blocks offered while idle must not start anything.
    bus.i_blk_valid = 1'b1;
    bus.i_blk_data = 128'h5;
    @(negedge clk);
    bus.i_blk_valid = 1'b0;
    check_eq("idle_blk_ignored", {127'd0, bus.o_busy}, 128'd0);

    // Reset in the middle of a sector discards the in-flight block.
    wait_tweak_ready();
    bus.i_tweak = 128'h1234;
    bus.i_tweak_valid = 1'b1;
    @(negedge clk);
    bus.i_tweak_valid = 1'b0;
    bus.i_blk_valid = 1'b1;
    bus.i_blk_data = 128'hABCD;
    @(negedge clk);
    bus.i_blk_valid = 1'b0;
    check_eq("rst_pre_valid_up", {127'd0, bus.o_pre_valid}, 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_post_valid = 1'b1;
    bus.i_post_data = 128'h77;
    @(negedge clk);
    bus.i_post_valid = 1'b0;
    check_reset_values("midrst");
    core_key = {$urandom, $urandom, $urandom, $urandom};
    run_sector({$urandom, $urandom, $urandom, $urandom}, MAX_BLK, 1'b1, 1'b0);

`ifdef SERPENT_XTS_ABORT_EN
    // Abort while waiting for the third block, then start over at once.
    run_sector(128'h99, 2, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", {127'd0, bus.o_busy}, 128'd0);
    check_eq("abort_data_valid", {127'd0, bus.o_data_valid}, 128'd0);
    check_eq("abort_pre_valid", {127'd0, bus.o_pre_valid}, 128'd0);
    check_eq("abort_tweak_ready", {127'd0, bus.o_tweak_ready}, 128'd1);
    run_sector({$urandom, $urandom, $urandom, $urandom}, MAX_BLK, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
